iot_event_scheduler: RTL and testbench

- Arbitrates connect/disconnect events from N_DEV IoT device ports onto the single change/on_off interface of the active-device counter monitor.
- At most one event is issued per two cycles, in round-robin order.
- Keeps a per-device active bitmap and rejects redundant or over-capacity events, so the monitor count never drifts from the real device population.
- Sits between the device-port front ends and the monitor counter.

---
 rtl/iot_event_scheduler.sv | 122 ++++++++++++
 tb/tb_iot_event_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/iot_event_scheduler.sv
// Round-robin connect/disconnect arbiter feeding the active-device monitor: ack/rej one cycle after sampling req, one event per 2 cycles.
// Losing requests stay pending until served; defining IOT_SCHED_STATS_EN adds a saturating rej_cnt output.
module iot_event_scheduler #(
    parameter int N_DEV      = 8,
    parameter int MAX_ACTIVE = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] req,
    input  logic [N_DEV-1:0] req_on,
    output logic [N_DEV-1:0] ack,
    output logic [N_DEV-1:0] rej,
    output logic             change,
    output logic             on_off,
    output logic [N_DEV-1:0] active_map,
    output logic [7:0]       active_cnt
`ifdef IOT_SCHED_STATS_EN
    ,
    output logic [15:0]      rej_cnt
`endif
);

    localparam int PW = $clog2(N_DEV);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t           state_q;
    logic [PW-1:0]    ptr_q;
    logic [N_DEV-1:0] ack_q;
    logic [N_DEV-1:0] rej_q;
    logic             change_q;
    logic             on_off_q;
    logic [N_DEV-1:0] active_map_q;
    logic [7:0]       active_cnt_q;

    logic             win_vld_d;
    logic [PW-1:0]    win_idx_d;
    logic [N_DEV-1:0] win_oh_d;
    logic             win_on_d;
    logic             accept_d;
    logic [N_DEV-1:0] active_map_d;
    logic [7:0]       active_cnt_d;

    // Walk downward from the farthest offset so the nearest requester after ptr_q wins.
    always_comb begin
        logic [PW-1:0] cand;
        win_vld_d = 1'b0;
        win_idx_d = '0;
        cand      = '0;
        for (int k = N_DEV; k >= 1; k--) begin
            cand = PW'((int'(ptr_q) + k) % N_DEV);
            if (req[cand]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand;
            end
        end
    end

    always_comb begin
        win_oh_d     = N_DEV'(1) << win_idx_d;
        win_on_d     = req_on[win_idx_d];
        accept_d     = (win_on_d != active_map_q[win_idx_d]) &&
                       !(win_on_d && (active_cnt_q == 8'(MAX_ACTIVE)));
        active_map_d = win_on_d ? (active_map_q | win_oh_d) : (active_map_q & ~win_oh_d);
        active_cnt_d = win_on_d ? (active_cnt_q + 8'd1) : (active_cnt_q - 8'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= PW'(N_DEV - 1);
            ack_q        <= '0;
            rej_q        <= '0;
            change_q     <= 1'b0;
            on_off_q     <= 1'b0;
            active_map_q <= '0;
            active_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (win_vld_d) begin
                state_q <= ISSUE;
                ptr_q   <= win_idx_d;
                if (accept_d) begin
                    ack_q        <= win_oh_d;
                    change_q     <= 1'b1;
                    on_off_q     <= win_on_d;
                    active_map_q <= active_map_d;
                    active_cnt_q <= active_cnt_d;
                end else begin
                    rej_q <= win_oh_d;
                end
            end
        end else begin
            state_q  <= IDLE;
            ack_q    <= '0;
            rej_q    <= '0;
            change_q <= 1'b0;
            on_off_q <= 1'b0;
        end
    end

`ifdef IOT_SCHED_STATS_EN
    logic [15:0] rej_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rej_cnt_q <= '0;
        end else if (state_q == IDLE && win_vld_d && !accept_d && rej_cnt_q != 16'hFFFF) begin
            rej_cnt_q <= rej_cnt_q + 16'd1;
        end
    end

    assign rej_cnt = rej_cnt_q;
`endif

    assign ack        = ack_q;
    assign rej        = rej_q;
    assign change     = change_q;
    assign on_off     = on_off_q;
    assign active_map = active_map_q;
    assign active_cnt = active_cnt_q;

endmodule

// File: tb/tb_iot_event_scheduler.sv
// Scoreboard bench for iot_event_scheduler: a transaction-level round-robin model predicts every ack/rej.
module tb_iot_event_scheduler;

    localparam int N    = 8;
    localparam int MAXA = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] req_on;
    logic [7:0] ack;
    logic [7:0] rej;
    logic       change;
    logic       on_off;
    logic [7:0] active_map;
    logic [7:0] active_cnt;
`ifdef IOT_SCHED_STATS_EN
    logic [15:0] rej_cnt;
`endif

    iot_event_scheduler #(.N_DEV(N), .MAX_ACTIVE(MAXA)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_on     (req_on),
        .ack        (ack),
        .rej        (rej),
        .change     (change),
        .on_off     (on_off),
        .active_map (active_map),
`ifdef IOT_SCHED_STATS_EN
        .rej_cnt    (rej_cnt),
`endif
        .active_cnt (active_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         dev;
        bit         is_ack;
        bit         on;
        logic [7:0] map;
        int         cnt;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_act;
    int         m_ptr;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int popc(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, expv, expv, cyc);
        end
    endtask

    // Monitor: pops one expectation per observed ack/rej pulse.
    initial begin
        exp_t       e;
        logic [7:0] oh;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("cnt_is_popcount", int'(active_cnt), popc(active_map));
                if ((ack | rej) != 8'h00) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: ack=%h rej=%h with no expected event", ack, rej);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = 8'(1) << e.dev;
                        chk("ack", int'(ack), e.is_ack ? int'(oh) : 0);
                        chk("rej", int'(rej), e.is_ack ? 0 : int'(oh));
                        chk("change", int'(change), int'(e.is_ack));
                        chk("on_off", int'(on_off), (e.is_ack && e.on) ? 1 : 0);
                        chk("active_map", int'(active_map), int'(e.map));
                        chk("active_cnt", int'(active_cnt), e.cnt);
                        chk("event_cycle", cyc, e.cyc);
                    end
                end else begin
                    chk("idle_change", int'(change), 0);
                    chk("idle_on_off", int'(on_off), 0);
                end
            end
        end
    end

    // Raise a set of requests at once, predict the whole service order, then play requester.
    task automatic issue_batch(input logic [7:0] rm, input logic [7:0] om);
        logic [7:0] pend;
        int         d, c, k, base, budget;
        bit         found;
        exp_t       x;
        @(negedge clk);
        pend = rm;
        k    = 0;
        base = cyc + 1;
        while (pend != 8'h00) begin
            d     = 0;
            found = 1'b0;
            for (int s = 1; s <= N; s++) begin
                c = (m_ptr + s) % N;
                if (!found && pend[3'(c)]) begin
                    d     = c;
                    found = 1'b1;
                end
            end
            x.dev    = d;
            x.on     = om[3'(d)];
            x.is_ack = (om[3'(d)] != m_act[3'(d)]) && !(om[3'(d)] && popc(m_act) == MAXA);
            if (x.is_ack) m_act[3'(d)] = om[3'(d)];
            x.map    = m_act;
            x.cnt    = popc(m_act);
            x.cyc    = base + 2 * k;
            exp_q.push_back(x);
            m_ptr         = d;
            pend[3'(d)]   = 1'b0;
            k++;
        end
        req    = rm;
        req_on = (om & rm) | (8'($urandom) & ~rm);
        budget = 4 * N + 8;
        while (req != 8'h00 && budget > 0) begin
            @(negedge clk);
            budget--;
            if ((ack | rej) != 8'h00) req = req & ~(ack | rej);
            req_on = (req_on & req) | (8'($urandom) & ~req);
        end
        if (req != 8'h00) begin
            checks++;
            errors++;
            $display("FAIL batch_timeout: req=%h still pending, required 00", req);
            req = 8'h00;
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b1;
        req    = 8'h00;
        req_on = 8'h00;
        m_act  = 8'h00;
        m_ptr  = N - 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_ack", int'(ack), 0);
            chk("rst_rej", int'(rej), 0);
            chk("rst_change", int'(change), 0);
            chk("rst_on_off", int'(on_off), 0);
            chk("rst_map", int'(active_map), 0);
            chk("rst_cnt", int'(active_cnt), 0);
        end
        mon_en = 1'b1;

        issue_batch(8'h01, 8'h01);
        issue_batch(8'h01, 8'h01);
        issue_batch(8'h0B, 8'h0B);
        issue_batch(8'h3F, 8'h3F);
        issue_batch(8'h40, 8'h40);
        issue_batch(8'h04, 8'h00);
        issue_batch(8'h40, 8'h40);
        for (int i = 0; i < 60; i++) begin
            issue_batch(8'($urandom_range(1, 255)), (i % 3 == 0) ? 8'hFF : 8'($urandom));
        end

        // Reset landing in the ISSUE cycle of a device 4 connect.
        issue_batch(8'hFF, 8'h00);
        mon_en = 1'b0;
        @(negedge clk);
        req    = 8'h10;
        req_on = 8'h10;
        @(negedge clk);
        chk("pre_rst_ack", int'(ack), 'h10);
        chk("pre_rst_change", int'(change), 1);
        rst = 1'b1;
        req = 8'h00;
        @(negedge clk);
        chk("mid_rst_ack", int'(ack), 0);
        chk("mid_rst_rej", int'(rej), 0);
        chk("mid_rst_change", int'(change), 0);
        chk("mid_rst_on_off", int'(on_off), 0);
        chk("mid_rst_map", int'(active_map), 0);
        chk("mid_rst_cnt", int'(active_cnt), 0);
        rst    = 1'b0;
        m_act  = 8'h00;
        m_ptr  = N - 1;
        mon_en = 1'b1;
`ifdef IOT_SCHED_STATS_EN
        chk("rej_cnt_after_rst", int'(rej_cnt), 0);
        repeat (3) issue_batch(8'h04, 8'h00);
        chk("rej_cnt_three", int'(rej_cnt), 3);
`endif
        issue_batch(8'hA8, 8'hA8);
        issue_batch(8'hFF, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
